// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// State encodings, Mem_Ctrl bit positions, core count and bus widths.
package dmem_arb_pkg;

  localparam int NCORES = 4;
  localparam int AW     = 8;
  localparam int DW     = 8;
  localparam int MC_W   = 4;
  localparam int CNT_W  = 2;

  localparam int MC_DREAD  = 0;
  localparam int MC_DWRITE = 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD   = 3'd2,
    ST_ACK  = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  function automatic logic [NCORES-1:0] onehot(
    input logic [1:0] idx
  );
    logic [NCORES-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Combinational 4-way round-robin picker.
// req: pending requests, last: previous grant; any: some req set, idx: pick.
module rr_pick
  import dmem_arb_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic       any,
  output logic [1:0] idx
);

  logic [3:0] rot;
  logic [1:0] off;

  // rot[i] is the request of core last+1+i, so the
  // lowest set bit of rot is the next core in turn.
  always_comb begin
    rot = '0;
    for (int i = 0; i < 4; i++) begin
      rot[i] = req[last + 2'(i + 1)];
    end
  end

  always_comb begin
    off = 2'd0;
    if (rot[0])      off = 2'd0;
    else if (rot[1]) off = 2'd1;
    else if (rot[2]) off = 2'd2;
    else             off = 2'd3;
  end

  assign any = |req;
  assign idx = last + 2'd1 + off;

endmodule

// File: rtl/dmem_arbiter.sv
// Four-core data-RAM arbiter: round-robin grant, one access at a time.
// Core side: Mem_Ctrl/DAddress/Ddout in, Ddin/dacq out; RAM side: ram_*; busy, gnt_id status.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int RAM_LAT = 1,
  parameter int NCORES  = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [MC_W*NCORES-1:0] Mem_Ctrl,
  input  logic [AW*NCORES-1:0]   DAddress,
  input  logic [DW*NCORES-1:0]   Ddout,
  output logic [DW-1:0]          Ddin,
  output logic [NCORES-1:0]      dacq,
  output logic [AW-1:0]          ram_addr,
  output logic [DW-1:0]          ram_wdata,
  output logic                   ram_we,
  input  logic [DW-1:0]          ram_rdata,
  output logic                   busy,
  output logic [1:0]             gnt_id
);

  state_t state;
  state_t nxt;

  logic [1:0]       last_grant;
  logic [CNT_W-1:0] cnt;

  logic [NCORES-1:0] req;
  logic [NCORES-1:0] req_wr;
  logic              unused_ctrl;

  logic       pick_any;
  logic [1:0] pick_idx;

  logic [1:0]        gnt_n;
  logic [1:0]        last_n;
  logic [AW-1:0]     addr_n;
  logic [DW-1:0]     wdata_n;
  logic              we_n;
  logic [DW-1:0]     ddin_n;
  logic [NCORES-1:0] dacq_n;
  logic [CNT_W-1:0]  cnt_n;

  always_comb begin
    req         = '0;
    req_wr      = '0;
    unused_ctrl = 1'b0;
    for (int k = 0; k < NCORES; k++) begin
      req[k]    = Mem_Ctrl[MC_W*k+MC_DREAD]
                | Mem_Ctrl[MC_W*k+MC_DWRITE];
      req_wr[k] = Mem_Ctrl[MC_W*k+MC_DWRITE];
      unused_ctrl = unused_ctrl
                  ^ Mem_Ctrl[MC_W*k+2]
                  ^ Mem_Ctrl[MC_W*k+3];
    end
  end

  rr_pick u_pick (
    .req  (req),
    .last (last_grant),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  always_comb begin
    nxt     = state;
    gnt_n   = gnt_id;
    last_n  = last_grant;
    addr_n  = ram_addr;
    wdata_n = ram_wdata;
    we_n    = 1'b0;
    ddin_n  = Ddin;
    dacq_n  = '0;
    cnt_n   = cnt;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_n   = pick_idx;
          last_n  = pick_idx;
          addr_n  = DAddress[AW*pick_idx +: AW];
          wdata_n = Ddout[DW*pick_idx +: DW];
          cnt_n   = '0;
          // Write wins when both op bits are set.
          if (req_wr[pick_idx]) begin
            nxt  = ST_WR;
            we_n = 1'b1;
          end else begin
            nxt = ST_RD;
          end
        end
      end
      ST_WR: begin
        nxt    = ST_ACK;
        dacq_n = onehot(gnt_id);
      end
      ST_RD: begin
        // Address went out on entry to RD; data is
        // valid RAM_LAT cycles later, in the last RD cycle.
        if (cnt == CNT_W'(RAM_LAT)) begin
          nxt    = ST_ACK;
          ddin_n = ram_rdata;
          dacq_n = onehot(gnt_id);
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_ACK: begin
        nxt = ST_GAP;
      end
      ST_GAP: begin
        nxt = ST_IDLE;
      end
      default: begin
        nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      gnt_id     <= 2'd0;
      last_grant <= 2'd3;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ram_we     <= 1'b0;
      Ddin       <= '0;
      dacq       <= '0;
      cnt        <= '0;
    end else begin
      state      <= nxt;
      gnt_id     <= gnt_n;
      last_grant <= last_n;
      ram_addr   <= addr_n;
      ram_wdata  <= wdata_n;
      ram_we     <= we_n;
      Ddin       <= ddin_n;
      dacq       <= dacq_n;
      cnt        <= cnt_n;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter.
// Two instances: RAM_LAT=1 (main checks) and RAM_LAT=3 (reset-in-read case).
module tb_dmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] mc;
  logic [31:0] da;
  logic [31:0] dd;

  logic [7:0] ddin1, raddr1, rwd1, rrd1;
  logic [3:0] dacq1;
  logic       rwe1, busy1;
  logic [1:0] gid1;

  logic [7:0] ddin3, raddr3, rwd3, rrd3;
  logic [3:0] dacq3;
  logic       rwe3, busy3;
  logic [1:0] gid3;

  dmem_arbiter #(.RAM_LAT(1), .NCORES(4)) u_dut1 (
    .CLK(clk), .RST(rst), .Mem_Ctrl(mc),
    .DAddress(da), .Ddout(dd), .Ddin(ddin1),
    .dacq(dacq1), .ram_addr(raddr1),
    .ram_wdata(rwd1), .ram_we(rwe1),
    .ram_rdata(rrd1), .busy(busy1), .gnt_id(gid1)
  );

  dmem_arbiter #(.RAM_LAT(3), .NCORES(4)) u_dut3 (
    .CLK(clk), .RST(rst), .Mem_Ctrl(mc),
    .DAddress(da), .Ddout(dd), .Ddin(ddin3),
    .dacq(dacq3), .ram_addr(raddr3),
    .ram_wdata(rwd3), .ram_we(rwe3),
    .ram_rdata(rrd3), .busy(busy3), .gnt_id(gid3)
  );

  // RAM models: not reset, write on we, read pipeline RAM_LAT deep
  logic [7:0] mem1 [256];
  logic [7:0] mem3 [256];
  logic [7:0] p0, p1;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem1[i] = 8'h00;
      mem3[i] = 8'h00;
    end
  end

  always @(posedge clk) begin
    if (rwe1) mem1[raddr1] <= rwd1;
    rrd1 <= mem1[raddr1];
    if (rwe3) mem3[raddr3] <= rwd3;
    p0   <= mem3[raddr3];
    p1   <= p0;
    rrd3 <= p1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  typedef struct {
    logic [3:0] dacq;
    logic [7:0] ddin;
    int         issue;
    int         lat;
  } exp_t;

  exp_t sbq[$];
  bit   sb_on = 1'b0;

  always @(negedge clk) begin : sb_mon
    exp_t e;
    if (sb_on && dacq1 != 4'h0) begin
      if (sbq.size() == 0) begin
        chk("unexpected_dacq", {28'h0, dacq1}, 32'h0);
      end else begin
        e = sbq.pop_front();
        chk("sb_dacq", {28'h0, dacq1}, {28'h0, e.dacq});
        chk("sb_ddin", {24'h0, ddin1}, {24'h0, e.ddin});
        if (e.lat >= 0)
          chk("sb_latency", cyc - e.issue, e.lat);
      end
    end
  end

  typedef struct {
    int         core;
    logic [1:0] ctl;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       exp_we;
    logic [7:0] exp_ddin;
    int         exp_lat;
  } vec_t;

  vec_t vt[9];

  task automatic drive(int core, logic [1:0] ctl,
                       logic [7:0] a, logic [7:0] d);
    mc[4*core +: 4] = {2'b00, ctl};
    da[8*core +: 8] = a;
    dd[8*core +: 8] = d;
  endtask

  task automatic wait_idle1();
    int t;
    t = 0;
    while (busy1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (busy1) chk("idle1_timeout", 32'h1, 32'h0);
  endtask

  task automatic wait_idle3();
    int t;
    t = 0;
    while (busy3 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (busy3) chk("idle3_timeout", 32'h1, 32'h0);
  endtask

  task automatic wait_dacq1(int core);
    int t;
    t = 0;
    while (!dacq1[core] && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!dacq1[core]) chk("dacq1_timeout", 32'h0, 32'h1);
  endtask

  task automatic wait_dacq3(int core);
    int t;
    t = 0;
    while (!dacq3[core] && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!dacq3[core]) chk("dacq3_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         issue;
    logic [3:0] acc;
    logic       bacc;

    vt[0] = '{1, 2'b10, 8'h10, 8'h5A, 1'b1, 8'h00, 2};
    vt[1] = '{2, 2'b01, 8'h10, 8'hEE, 1'b0, 8'h5A, 3};
    vt[2] = '{0, 2'b11, 8'hFF, 8'h33, 1'b1, 8'h5A, 2};
    vt[3] = '{3, 2'b01, 8'hFF, 8'hEE, 1'b0, 8'h33, 3};
    vt[4] = '{0, 2'b10, 8'h00, 8'hC3, 1'b1, 8'h33, 2};
    vt[5] = '{1, 2'b01, 8'h00, 8'hEE, 1'b0, 8'hC3, 3};
    vt[6] = '{2, 2'b10, 8'h80, 8'h7E, 1'b1, 8'hC3, 2};
    vt[7] = '{3, 2'b01, 8'h80, 8'hEE, 1'b0, 8'h7E, 3};
    vt[8] = '{0, 2'b01, 8'h10, 8'hEE, 1'b0, 8'h5A, 3};

    rst = 1'b1;
    mc  = '0;
    da  = '0;
    dd  = '0;
    repeat (3) @(negedge clk);
    chk("rst_dacq",  {28'h0, dacq1}, 32'h0);
    chk("rst_we",    {31'h0, rwe1},  32'h0);
    chk("rst_addr",  {24'h0, raddr1}, 32'h0);
    chk("rst_wdata", {24'h0, rwd1},  32'h0);
    chk("rst_ddin",  {24'h0, ddin1}, 32'h0);
    chk("rst_busy",  {31'h0, busy1}, 32'h0);
    chk("rst_gnt",   {30'h0, gid1},  32'h0);
    rst   = 1'b0;
    sb_on = 1'b1;

    // Single-core accesses from the vector table
    for (int i = 0; i < 9; i++) begin
      wait_idle1();
      drive(vt[i].core, vt[i].ctl, vt[i].addr, vt[i].wdata);
      sbq.push_back('{4'(1 << vt[i].core), vt[i].exp_ddin,
                      cyc, vt[i].exp_lat});
      @(negedge clk);
      chk("v_we",   {31'h0, rwe1},   {31'h0, vt[i].exp_we});
      chk("v_addr", {24'h0, raddr1}, {24'h0, vt[i].addr});
      chk("v_gnt",  {30'h0, gid1},   vt[i].core);
      if (vt[i].exp_we)
        chk("v_wdata", {24'h0, rwd1}, {24'h0, vt[i].wdata});
      wait_dacq1(vt[i].core);
      mc = '0;
      @(negedge clk);
      chk("v_dacq_width", {28'h0, dacq1}, 32'h0);
      chk("v_we_off",     {31'h0, rwe1},  32'h0);
      chk("v_ddin_hold",  {24'h0, ddin1}, {24'h0, vt[i].exp_ddin});
    end

    // All four cores request right after reset
    wait_idle1();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++)
      drive(k, 2'b10, 8'(8'h20 + k), 8'(8'hA0 + k));
    issue = cyc;
    for (int k = 0; k < 4; k++)
      sbq.push_back('{4'(1 << k), 8'h00, issue, (k == 0) ? 2 : -1});
    for (int k = 0; k < 4; k++) begin
      wait_dacq1(k);
      mc[4*k +: 4] = 4'h0;
      @(negedge clk);
      chk("rr_dacq_width", {28'h0, dacq1}, 32'h0);
    end
    acc = '0;
    repeat (8) begin
      @(negedge clk);
      acc = acc | dacq1;
    end
    chk("rr_no_regrant", {28'h0, acc}, 32'h0);
    chk("rr_busy_done",  {31'h0, busy1}, 32'h0);
    chk("rr_mem_core3",  {24'h0, mem1[8'h23]}, 32'hA3);

    // Core3 keeps requesting through GAP
    wait_idle1();
    drive(3, 2'b10, 8'h30, 8'h11);
    sbq.push_back('{4'b1000, 8'h00, cyc, 2});
    wait_dacq1(3);
    @(negedge clk);
    chk("gap_busy", {31'h0, busy1}, 32'h1);
    @(negedge clk);
    chk("gap_then_idle", {31'h0, busy1}, 32'h0);
    mc = '0;
    acc  = '0;
    bacc = 1'b0;
    repeat (6) begin
      @(negedge clk);
      acc  = acc | dacq1;
      bacc = bacc | busy1;
    end
    chk("gap_no_regrant", {28'h0, acc}, 32'h0);
    chk("gap_stay_idle",  {31'h0, bacc}, 32'h0);
    chk("sb_drained", sbq.size(), 0);

    // Reset in the middle of a RAM_LAT=3 read
    sb_on = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(2, 2'b01, 8'h30, 8'hEE);
    @(negedge clk);
    @(negedge clk);
    chk("rd_in_progress", {31'h0, busy3}, 32'h1);
    rst = 1'b1;
    mc  = '0;
    @(negedge clk);
    chk("mid_dacq",  {28'h0, dacq3}, 32'h0);
    chk("mid_we",    {31'h0, rwe3},  32'h0);
    chk("mid_addr",  {24'h0, raddr3}, 32'h0);
    chk("mid_wdata", {24'h0, rwd3},  32'h0);
    chk("mid_ddin",  {24'h0, ddin3}, 32'h0);
    chk("mid_busy",  {31'h0, busy3}, 32'h0);
    chk("mid_gnt",   {30'h0, gid3},  32'h0);
    rst = 1'b0;
    acc = '0;
    repeat (8) begin
      @(negedge clk);
      acc = acc | dacq3;
    end
    chk("mid_no_dacq", {28'h0, acc}, 32'h0);

    // Normal traffic after the aborted read
    wait_idle3();
    drive(1, 2'b10, 8'h22, 8'h99);
    issue = cyc;
    wait_dacq3(1);
    chk("post_wr_lat", cyc - issue, 2);
    mc = '0;
    @(negedge clk);
    wait_idle3();
    drive(1, 2'b01, 8'h22, 8'hEE);
    issue = cyc;
    wait_dacq3(1);
    chk("post_rd_lat",  cyc - issue, 5);
    chk("post_rd_dacq", {28'h0, dacq3}, 32'h2);
    chk("post_rd_data", {24'h0, ddin3}, 32'h99);
    mc = '0;
    @(negedge clk);
    chk("post_rd_hold", {24'h0, ddin3}, 32'h99);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
